instruction_queue_decode: RTL
=============================

// Module: instruction_queue_decode
// PURPOSE
//  Buffered successor to the single-entry instruction register. A DEPTH-entry FIFO of raw
//  instructions from fetch/memory feeds one decoded output stage. Valid/ready handshakes on
//  both sides let fetch run ahead of the controller. Immediate is zero- or sign-extended
//  per instruction. Sits between instruction memory and the controller/regfile/ALU.
// PARAMETERS
//  WIDTH             16  instruction and immediate_value width
//  REG_BITS          4   register index width
//  OP_CODE_BITS      4   opcode field width
//  EXT_OP_CODE_BITS  4   extended opcode field width
//  IMM_BITS          8   immediate field width (IMM_BITS < WIDTH)
//  DEPTH             4   FIFO entries; power of 2, >= 2
// PORTS
//  clk             in   1                        rising-edge clock
//  reset           in   1                        synchronous, active-low reset
//  flush           in   1                        discard all queued and decoded instructions
//  in_valid        in   1                        in_instruction is valid
//  in_ready        out  1                        queue can accept this cycle
//  in_instruction  in   WIDTH                    raw instruction
//  sign_ext        in   1                        qualifies in_instruction: 1 = sign-extend imm
//  out_valid       out  1                        decoded fields are valid
//  out_ready       in   1                        consumer takes decoded instruction this cycle
//  op_code         out  OP_CODE_BITS             instr[WIDTH-1 -: OP_CODE_BITS]
//  A_index_out     out  REG_BITS                 instr[WIDTH-OP_CODE_BITS-1 -: REG_BITS]
//  ext_op_code     out  EXT_OP_CODE_BITS         instr[IMM_BITS-1 -: EXT_OP_CODE_BITS]
//  B_index_out     out  REG_BITS                 instr[REG_BITS-1:0]
//  immediate_value out  WIDTH                    instr[IMM_BITS-1:0], zero/sign-extended
//  count           out  $clog2(DEPTH+1)          FIFO occupancy (excludes output stage)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): FIFO emptied, count=0, out_valid=0, all field outputs=0.
//    in_ready=0 while reset is low; afterwards in_ready = (count != DEPTH), purely from state.
//  - Push: in_valid && in_ready. sign_ext is stored with the instruction (WIDTH+1 bits/entry).
//  - Output stage load condition: load = !out_valid || out_ready.
//    On load, take the FIFO head if count>0. Otherwise take a push in the same cycle (bypass).
//    Otherwise out_valid <= 0 and the fields hold.
//  - Latency: a push into an empty queue with load true is on the outputs after the same edge
//    (1 cycle). Otherwise it appears after the entries ahead of it.
//  - Order is strictly FIFO. Bypass is used only when count==0, so ordering is never broken.
//  - Simultaneous push and FIFO pop: count unchanged. Push while full: impossible (in_ready=0).
//    No combinational path from out_ready to in_ready.
//  - Pointers are log2(DEPTH) bits and wrap naturally. Full/empty come from count, not pointers.
//  - Fields hold their value whenever no load occurs, so the consumer may sample them while
//    out_valid=1 && !out_ready.
//  - Extension: sign_ext=1 replicates instr[IMM_BITS-1] into the upper WIDTH-IMM_BITS bits.
//    Otherwise the upper bits are zero. Fields overlap by design (ext_op_code/B inside imm).
//  - Flush (reset high): count<=0, pointers<=0, out_valid<=0, fields hold. A push in the same
//    cycle is dropped. Flush has priority over push, pop and load. Reset has priority over flush.
//  - Reset asserted mid-stream discards everything. The first post-reset push behaves as
//    empty-queue bypass.
// TESTING
//  1 Reset then push 16'h3A5F, sign_ext=0, out_ready=1 -> next cycle out_valid=1, op=3, A=A,
//    ext=5, B=F, imm=16'h005F, count=0.
//  2 Push 16'h1284 with sign_ext=1 -> imm=16'hFF84. Push the same word with sign_ext=0 ->
//    imm=16'h0084.
//  3 out_ready=0, push 5 words back to back -> word1 on outputs, count=4, in_ready=0.
//    Raise out_ready -> words 2..5 appear in order, one per cycle. in_ready=1 after the first pop.
//  4 count=2, out_valid=1, push and out_ready in the same cycle -> count stays 2, head advances,
//    no loss or duplication across a pointer wrap (run 3*DEPTH words).
//  5 count=3, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, pushed word absent.
//    Fields equal the pre-flush values.
//  6 Drive reset low mid-stream with a full queue -> count=0, out_valid=0, fields=0,
//    in_ready=0 during reset, 1 after.

Source files
------------

// File: rtl/instruction_queue_decode_if.sv
// Handshake and decoded-field bundle between the instruction queue and its
// neighbours: fetch pushes raw words in, the controller pops decoded fields out.
interface instruction_queue_decode_if #(
  parameter int WIDTH            = 16,
  parameter int REG_BITS         = 4,
  parameter int OP_CODE_BITS     = 4,
  parameter int EXT_OP_CODE_BITS = 4,
  parameter int DEPTH            = 4
);

  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in_instruction;
  logic                         sign_ext;
  logic                         out_valid;
  logic                         out_ready;
  logic [OP_CODE_BITS-1:0]      op_code;
  logic [REG_BITS-1:0]          A_index_out;
  logic [EXT_OP_CODE_BITS-1:0]  ext_op_code;
  logic [REG_BITS-1:0]          B_index_out;
  logic [WIDTH-1:0]             immediate_value;
  logic [$clog2(DEPTH+1)-1:0]   count;

  // Fetch/controller side: drives pushes, flush and consumer ready.
  modport master (
    output flush, in_valid, in_instruction, sign_ext, out_ready,
    input  in_ready, out_valid, op_code, A_index_out, ext_op_code,
           B_index_out, immediate_value, count
  );

  // Queue side: accepts pushes and presents decoded fields.
  modport slave (
    input  flush, in_valid, in_instruction, sign_ext, out_ready,
    output in_ready, out_valid, op_code, A_index_out, ext_op_code,
           B_index_out, immediate_value, count
  );

endinterface

// File: rtl/instruction_queue_decode.sv
// Instruction queue with a decoded output stage. Raw instructions (plus their
// sign-extension flag) are buffered in a small FIFO; the head is moved into an
// output register whenever that register is empty or being consumed. When the
// FIFO is empty a push goes straight into the output stage so an idle pipeline
// sees one-cycle latency.
module instruction_queue_decode #(
  parameter int WIDTH            = 16,
  parameter int REG_BITS         = 4,
  parameter int OP_CODE_BITS     = 4,
  parameter int EXT_OP_CODE_BITS = 4,
  parameter int IMM_BITS         = 8,
  parameter int DEPTH            = 4
) (
  input logic                   clk,
  input logic                   reset,
  instruction_queue_decode_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = WIDTH + 1;
  localparam int UPPER_W = WIDTH - IMM_BITS;

  logic [ENTRY_W-1:0] fifoMem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               outValid_q, outValid_d;
  logic [WIDTH-1:0]   outInstr_q, outInstr_d;
  logic               outSext_q, outSext_d;

  logic               fifoEmpty;
  logic               fifoFull;
  logic               push;
  logic               load;
  logic               popFifo;
  logic               bypass;
  logic               pushFifo;
  logic [ENTRY_W-1:0] headEntry;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CNT_W'(DEPTH));

  // Ready depends only on reset and occupancy, never on out_ready.
  assign bus.in_ready = reset && !fifoFull;

  assign push      = bus.in_valid && bus.in_ready;
  assign load      = !outValid_q || bus.out_ready;
  assign popFifo   = load && !fifoEmpty;
  assign bypass    = load && fifoEmpty && push;
  assign pushFifo  = push && !bypass;
  assign headEntry = fifoMem_q[rdPtr_q];

  // Next-state for pointers, occupancy and the output stage; flush wins over everything.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    outValid_d = outValid_q;
    outInstr_d = outInstr_q;
    outSext_d  = outSext_q;
    if (bus.flush) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      outValid_d = 1'b0;
    end else begin
      if (pushFifo) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popFifo) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(pushFifo) - CNT_W'(popFifo);
      if (load) begin
        if (popFifo) begin
          outValid_d = 1'b1;
          outSext_d  = headEntry[WIDTH];
          outInstr_d = headEntry[WIDTH-1:0];
        end else if (bypass) begin
          outValid_d = 1'b1;
          outSext_d  = bus.sign_ext;
          outInstr_d = bus.in_instruction;
        end else begin
          outValid_d = 1'b0;
        end
      end
    end
  end

  // Control and output-stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      outValid_q <= 1'b0;
      outInstr_q <= '0;
      outSext_q  <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      outValid_q <= outValid_d;
      outInstr_q <= outInstr_d;
      outSext_q  <= outSext_d;
    end
  end

  // FIFO storage; an entry is only written when the push is not bypassed or flushed.
  always_ff @(posedge clk) begin
    if (reset && !bus.flush && pushFifo) begin
      fifoMem_q[wrPtr_q] <= {bus.sign_ext, bus.in_instruction};
    end
  end

  // Field decode from the held output instruction; fields overlap intentionally.
  always_comb begin
    bus.out_valid   = outValid_q;
    bus.count       = count_q;
    bus.op_code     = outInstr_q[WIDTH-1 -: OP_CODE_BITS];
    bus.A_index_out = outInstr_q[WIDTH-OP_CODE_BITS-1 -: REG_BITS];
    bus.ext_op_code = outInstr_q[IMM_BITS-1 -: EXT_OP_CODE_BITS];
    bus.B_index_out = outInstr_q[REG_BITS-1:0];
    if (outSext_q) begin
      bus.immediate_value = {{UPPER_W{outInstr_q[IMM_BITS-1]}}, outInstr_q[IMM_BITS-1:0]};
    end else begin
      bus.immediate_value = {{UPPER_W{1'b0}}, outInstr_q[IMM_BITS-1:0]};
    end
  end

endmodule
